stutter_scheduler: RTL and testbench
====================================

# stutter_scheduler

Central stutter controller for a source/target pair of stutter-driven program models, e.g. a source code block and its optimized target running side by side. Each program flags when its next step is an observable write. The scheduler stutters whichever program reaches its observation point first until the other catches up, so both commit observations on the same edge. It also bounds waiting with a timeout, counts synchronized observations, and freezes both programs once each has terminated or a fault occurs.

## Interface
- MAX_WAIT, 7: maximum consecutive cycles one program may be held at an observation point before fault.
- WAIT_W, 3: width of the wait counter; must hold MAX_WAIT.
- SYNC_W, 4: width of the sync event counter.
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; leave IDLE and begin scheduling.
- obs_a  input  1  program A's next non-stuttered edge performs its observable write.
- obs_b  input  1  same for program B.
- done_a  input  1  program A is in its terminal step.
- done_b  input  1  same for program B.
- stutter_a  output  1  combinational; drives program A's stutter_in.
- stutter_b  output  1  combinational; drives program B's stutter_in.
- sync  output  1  combinational; high in a cycle where both programs commit observations on the coming edge.
- sync_cnt  output  SYNC_W  registered count of sync cycles.
- fault  output  1  registered, sticky; a wait timeout occurred.
- halted  output  1  registered; both programs are done.

## Operation
- States: IDLE, RUN, HALT, FAULT.
- **IDLE:** stutter_a = stutter_b = 1, sync = 0. Go to RUN on start = 1.
- **RUN, per side X (other side Y):** stutter_X = done_X | (obs_X & ~obs_Y & ~done_Y).
  - A program at an observation point is held while its partner is still computing.
  - A done program is always held.
  - If the partner is done, the waiting program is released, giving unmatched trailing observations.
- **sync (RUN only):** sync = obs_a & obs_b & ~done_a & ~done_b. Both stutters are 0 that cycle; sync_cnt increments and wraps modulo 2^SYNC_W.
- **Wait counter:** one shared counter.
  - Increments in any RUN cycle where exactly one of stutter_a or stutter_b is 1 because of obs (not because of done).
  - Clears on any other cycle.
  - When the counter equals MAX_WAIT and would increment: go to FAULT and set fault = 1.
- **HALT:** entered from RUN on the edge where done_a & done_b is sampled. Both stutters = 1, halted = 1. Absorbing; only rst leaves it.
- **FAULT:** both stutters = 1, fault = 1. Absorbing; only rst leaves it.
- **Priority in RUN:** done_a & done_b (HALT) beats a timeout (FAULT).
- **start:** sampled only in IDLE.
- **Reset:** state = IDLE, wait counter = 0, sync_cnt = 0, fault = 0, halted = 0.
  - Outputs after reset: stutter_a = 1, stutter_b = 1, sync = 0.
  - Reset mid-operation abandons any wait immediately; the attached programs are not reset by this block.

## Timing
- stutter_a, stutter_b and sync are combinational from the current state and current inputs, with zero latency. The program models register stutter_in on the same edge.
- IDLE to RUN: start is high at edge t; the first cycle with stutters possibly 0 is the cycle after t.
- Timeout: with obs_a = 1 and obs_b = 0 held from cycle c, stutter_a is 1 in cycles c .. c+MAX_WAIT.
  - The counter reaches MAX_WAIT at edge c+MAX_WAIT−1.
  - FAULT is entered at edge c+MAX_WAIT; fault reads 1 from cycle c+MAX_WAIT+1.
- sync_cnt updates on the edge that closes the sync cycle.
- halted asserts the cycle after done_a & done_b is first sampled in RUN.

## Configuration
- STUTTER_SCHED_TIMEOUT_EN defined: wait counter and FAULT state are present, as described above.
- Not defined:
  - Wait counter and FAULT state are removed; fault is tied to 0.
  - Waiting is unbounded.
  - MAX_WAIT and WAIT_W are ignored.

## Test plan
- **Reset and start:** rst for 2 cycles, then start = 0 for 3 cycles.
  - stutter_a = stutter_b = 1, sync_cnt = 0, fault = 0, halted = 0 throughout.
  - Then start = 1: both stutters are 0 next cycle (with obs = 0).
- **Aligned observation:** obs_a = obs_b = 1 in the same RUN cycle.
  - sync = 1, both stutters = 0, sync_cnt goes from 0 to 1.
  - Repeat 16 times with SYNC_W = 4: sync_cnt wraps to 0.
- **Skewed observation:** obs_a = 1 for 3 cycles before obs_b rises.
  - stutter_a = 1 and stutter_b = 0 for those 3 cycles.
  - Then sync = 1 with both stutters 0, and the wait counter clears.
- **Timeout (macro defined, MAX_WAIT = 7):** obs_b = 1, obs_a = 0 held.
  - stutter_b = 1 for 8 cycles, then fault = 1 and both stutters = 1.
  - State stays FAULT until rst.
- **Timeout (macro not defined):** same stimulus for 50 cycles; fault stays 0 and stutter_b stays 1.
- **Termination:**
  - done_a = 1 with obs_b = 1: stutter_a = 1, stutter_b = 0, no sync.
  - Then done_b = 1: halted = 1 next cycle and both stutters = 1.
  - done_a & done_b in the same cycle as a timeout edge: HALT is entered and fault stays 0.

Source files
------------

// File: rtl/stutter_scheduler.sv
// Stutter scheduler: holds whichever of two programs reaches its observation point first so both commit together.
// Optional wait timeout and FAULT state are enabled by defining STUTTER_SCHED_TIMEOUT_EN.
module stutter_scheduler #(
    parameter int MAX_WAIT = 7,
    parameter int WAIT_W   = 3,
    parameter int SYNC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              obs_a,
    input  logic              obs_b,
    input  logic              done_a,
    input  logic              done_b,
    output logic              stutter_a,
    output logic              stutter_b,
    output logic              sync,
    output logic [SYNC_W-1:0] sync_cnt,
    output logic              fault,
    output logic              halted
);

`ifdef STUTTER_SCHED_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;
`endif

    state_t state_q;
    state_t state_d;
    logic   both_done;
    logic   obs_wait;
    logic   timeout;

    assign both_done = done_a & done_b;

`ifdef STUTTER_SCHED_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    logic [WAIT_W-1:0] wait_q;
    logic              fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        stutter_a = 1'b1;
        stutter_b = 1'b1;
        sync      = 1'b0;
        obs_wait  = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                stutter_a = done_a | (obs_a & ~obs_b & ~done_b);
                stutter_b = done_b | (obs_b & ~obs_a & ~done_a);
                sync      = obs_a & obs_b & ~done_a & ~done_b;
                // Exactly one side held at its observation point; holds caused by done never count.
                obs_wait  = ~done_a & ~done_b & (obs_a ^ obs_b);
`ifdef STUTTER_SCHED_TIMEOUT_EN
                timeout   = obs_wait & (wait_q == WAIT_LIM);
`endif
                if (both_done) begin
                    state_d = HALT;
`ifdef STUTTER_SCHED_TIMEOUT_EN
                end else if (timeout) begin
                    state_d = FAULT;
`endif
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_cnt <= '0;
            halted   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sync) begin
                sync_cnt <= sync_cnt + 1'b1;
            end
            if ((state_q == RUN) && both_done) begin
                halted <= 1'b1;
            end
        end
    end

`ifdef STUTTER_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (obs_wait && !timeout) begin
                wait_q <= wait_q + 1'b1;
            end else begin
                wait_q <= '0;
            end
            if (timeout && !both_done) begin
                fault_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stutter_scheduler.sv
// Bench for stutter_scheduler: directed scenarios plus random traffic against a behavioural model.
// Follows STUTTER_SCHED_TIMEOUT_EN in the same way as the design.
module tb_stutter_scheduler;
    localparam int MAX_WAIT = 7;
    localparam int WAIT_W   = 3;
    localparam int SYNC_W   = 4;
`ifdef STUTTER_SCHED_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    logic clk = 1'b0;
    logic rst, start, obs_a, obs_b, done_a, done_b;
    logic stutter_a, stutter_b, sync, fault, halted;
    logic [SYNC_W-1:0] sync_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    int m_mode;
    int m_wait;
    int m_syncs;
    bit m_fault;
    bit m_halted;

    always #5 clk = ~clk;

    stutter_scheduler #(
        .MAX_WAIT(MAX_WAIT),
        .WAIT_W  (WAIT_W),
        .SYNC_W  (SYNC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .obs_a    (obs_a),
        .obs_b    (obs_b),
        .done_a   (done_a),
        .done_b   (done_b),
        .stutter_a(stutter_a),
        .stutter_b(stutter_b),
        .sync     (sync),
        .sync_cnt (sync_cnt),
        .fault    (fault),
        .halted   (halted)
    );

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_wait   = 0;
        m_syncs  = 0;
        m_fault  = 1'b0;
        m_halted = 1'b0;
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance the model, cross the edge.
    task automatic cycle(input bit r, input bit s, input bit oa, input bit ob, input bit da, input bit db);
        bit ea, eb, es;
        rst = r; start = s; obs_a = oa; obs_b = ob; done_a = da; done_b = db;
        @(negedge clk);
        if (m_mode == M_RUN) begin
            ea = da || (oa && !ob && !db);
            eb = db || (ob && !oa && !da);
            es = oa && ob && !da && !db;
        end else begin
            ea = 1'b1;
            eb = 1'b1;
            es = 1'b0;
        end
        check_val("stutter_a", stutter_a, ea);
        check_val("stutter_b", stutter_b, eb);
        check_val("sync", sync, es);
        check_val("sync_cnt", sync_cnt, m_syncs);
        check_val("fault", fault, m_fault);
        check_val("halted", halted, m_halted);
        if (r) begin
            model_reset();
        end else if (m_mode == M_IDLE) begin
            if (s) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (es) m_syncs = (m_syncs + 1) % (1 << SYNC_W);
            if (da && db) begin
                m_mode   = M_HALT;
                m_halted = 1'b1;
                m_wait   = 0;
            end else if (TMO && !da && !db && (ea != eb)) begin
                if (m_wait == MAX_WAIT) begin
                    m_mode  = M_FAULT;
                    m_fault = 1'b1;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        bit r, s, oa, ob, da, db;
        rst = 1'b1; start = 1'b0; obs_a = 1'b0; obs_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset, idle with start low, then start.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Aligned observations, 16 times so sync_cnt wraps.
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 1, 0, 0);
            cycle(0, 0, 0, 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 0, 0);

        // Skewed observation: A waits 3 cycles for B.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0, 0);

        // B held alone: timeout if enabled, unbounded wait otherwise.
        restart();
        for (int i = 0; i < 50; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 1, 1, 1, 0, 0);
        restart();
        cycle(0, 0, 1, 1, 0, 0);

        // Termination: A done while B observes, then B done.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 0);

        // Both done on the cycle that would otherwise time out.
        restart();
        for (int i = 0; i < MAX_WAIT; i++) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0);

        // Random traffic.
        restart();
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0) ||
                 ((m_mode == M_HALT || m_mode == M_FAULT) && $urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 3) == 0);
            oa = ($urandom_range(0, 2) != 0);
            ob = ($urandom_range(0, 2) != 0);
            da = ($urandom_range(0, 39) == 0);
            db = ($urandom_range(0, 39) == 0);
            cycle(r, s, oa, ob, da, db);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
